// File: rtl/runway_pkg.sv
// runway_pkg: shared definitions for the runway lights pattern decoder.
//   - PAT_A..PAT_D : the four legal light patterns
//   - dir_t        : decoded wind/switch code (2'b11 is never used)
//   - dec_state_t  : decoder FSM states
//   - pat_legal()  : true when a pattern is one of the four legal ones
package runway_pkg;

  localparam logic [2:0] PAT_A = 3'b001;
  localparam logic [2:0] PAT_B = 3'b010;
  localparam logic [2:0] PAT_C = 3'b100;
  localparam logic [2:0] PAT_D = 3'b101;

  typedef enum logic [1:0] {
    DIR_CALM = 2'b00,
    DIR_W01  = 2'b01,
    DIR_W10  = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } dec_state_t;

  function automatic logic pat_legal(input logic [2:0] p);
    return (p == PAT_A) || (p == PAT_B) || (p == PAT_C) || (p == PAT_D);
  endfunction

endpackage

// File: rtl/runway_xition_classify.sv
// runway_xition_classify: combinational classifier for one pattern transition.
// Ports:
//   prev  in  3  previously accepted pattern
//   cur   in  3  newly sampled pattern
//   legal out 1  transition is one of the twelve listed pairs
//   cls   out 2  class of the transition (valid only when legal=1)
// Any pair not listed (repeats, illegal patterns, D->D, ...) is illegal.
module runway_xition_classify
  import runway_pkg::*;
(
  input  logic [2:0] prev,
  input  logic [2:0] cur,
  output logic       legal,
  output dir_t       cls
);

  always_comb begin
    legal = 1'b1;
    cls   = DIR_CALM;
    case ({prev, cur})
      // calm
      {PAT_A, PAT_D}, {PAT_B, PAT_D}, {PAT_C, PAT_D}, {PAT_D, PAT_B}: cls = DIR_CALM;
      // wind01
      {PAT_A, PAT_B}, {PAT_B, PAT_C}, {PAT_C, PAT_A}, {PAT_D, PAT_A}: cls = DIR_W01;
      // wind10
      {PAT_A, PAT_C}, {PAT_C, PAT_B}, {PAT_B, PAT_A}, {PAT_D, PAT_C}: cls = DIR_W10;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/runway_decoder.sv
// runway_decoder: observes the runway lights pattern bus and infers which
// wind/switch code drives the pattern generator. A direction is reported
// once CONFIRM consecutive transitions of the same class have been seen.
// Ports:
//   clk        in  1  system clock, rising edge
//   reset      in  1  asynchronous active-high reset
//   sample_en  in  1  pat is evaluated only when 1
//   pat        in  3  observed light pattern
//   dir        out 2  decoded code (00 calm, 01 wind01, 10 wind10)
//   dir_valid  out 1  dir is locked
//   dir_change out 1  pulse when dir_valid rises or locked dir changes
//   err        out 1  pulse on illegal pattern / illegal transition
//   err_count  out 8  saturating error count (only with RUNWAY_DECODER_ERRCNT_EN)
// Optional feature macro: RUNWAY_DECODER_ERRCNT_EN
module runway_decoder
  import runway_pkg::*;
#(
  parameter int CONFIRM = 3,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [2:0] pat,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       dir_change,
`ifdef RUNWAY_DECODER_ERRCNT_EN
  output logic [7:0] err_count,
`endif
  output logic       err
);

  localparam logic [CNT_W-1:0] CONF_C = CNT_W'(CONFIRM);

  dec_state_t       state_reg, state_next;
  logic [2:0]       prev_reg, prev_next;
  dir_t             cand_reg, cand_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  dir_t             dir_reg, dir_next;
  logic             valid_reg, valid_next;
  logic             change_reg, change_next;
  logic             err_reg, err_next;

  logic             x_legal;
  dir_t             x_cls;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] cnt_upd;

  runway_xition_classify u_classify (
    .prev  (prev_reg),
    .cur   (pat),
    .legal (x_legal),
    .cls   (x_cls)
  );

  // Agreement counter: continue the run only if it is the same class and a
  // run is actually in progress (cnt==0 right after IDLE), saturate at CONFIRM.
  assign cnt_sat = (cnt_reg >= CONF_C) ? CONF_C : cnt_reg + 1'b1;
  assign cnt_upd = ((x_cls == cand_reg) && (cnt_reg != '0)) ? cnt_sat : CNT_W'(1);

  always_comb begin
    state_next  = state_reg;
    prev_next   = prev_reg;
    cand_next   = cand_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    valid_next  = valid_reg;
    change_next = 1'b0;
    err_next    = 1'b0;

    if (sample_en) begin
      if (state_reg == IDLE) begin
        if (pat_legal(pat)) begin
          prev_next  = pat;
          cnt_next   = '0;
          state_next = TRACK;
        end else begin
          err_next = 1'b1;
        end
      end else if (!x_legal) begin
        err_next   = 1'b1;
        valid_next = 1'b0;
        state_next = IDLE;
      end else begin
        prev_next = pat;
        cand_next = x_cls;
        cnt_next  = cnt_upd;
        if (cnt_upd == CONF_C) begin
          // Covers the initial lock, staying locked on agreement, and the
          // immediate re-lock to a new class when CONFIRM==1.
          dir_next    = x_cls;
          valid_next  = 1'b1;
          state_next  = LOCKED;
          change_next = (state_reg == TRACK) || (x_cls != dir_reg);
        end else begin
          valid_next = 1'b0;
          state_next = TRACK;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      prev_reg   <= 3'b000;
      cand_reg   <= DIR_CALM;
      cnt_reg    <= '0;
      dir_reg    <= DIR_CALM;
      valid_reg  <= 1'b0;
      change_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      prev_reg   <= prev_next;
      cand_reg   <= cand_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      valid_reg  <= valid_next;
      change_reg <= change_next;
      err_reg    <= err_next;
    end
  end

`ifdef RUNWAY_DECODER_ERRCNT_EN
  logic [7:0] err_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_reg <= 8'h00;
    end else if (err_next && (err_count_reg != 8'hFF)) begin
      err_count_reg <= err_count_reg + 8'h01;
    end
  end

  assign err_count = err_count_reg;
`endif

  assign dir        = dir_reg;
  assign dir_valid  = valid_reg;
  assign dir_change = change_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_runway_decoder.sv
// tb_runway_decoder: directed self-checking bench for runway_decoder
// (CONFIRM=3). Inputs change on the falling edge; outputs are checked on the
// falling edge after the sampling rising edge.
module tb_runway_decoder;
  import runway_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b0;
  logic [2:0] pat = 3'b000;
  logic [1:0] dir;
  logic       dir_valid;
  logic       dir_change;
  logic       err;
`ifdef RUNWAY_DECODER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] A = 3'b001;
  localparam logic [2:0] B = 3'b010;
  localparam logic [2:0] C = 3'b100;
  localparam logic [2:0] D = 3'b101;
  localparam logic [2:0] X = 3'b111;

  runway_decoder #(.CONFIRM(3), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .pat        (pat),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .dir_change (dir_change),
`ifdef RUNWAY_DECODER_ERRCNT_EN
    .err_count  (err_count),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge with outputs
  // reflecting this sample.
  task automatic samp(input logic [2:0] p);
    pat       = p;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    $display("sample pat=%b -> dir=%b valid=%b change=%b err=%b",
             p, dir, dir_valid, dir_change, err);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] d, input logic v,
                         input logic c, input logic e);
    chk({tag, ".dir"}, 8'(dir), 8'(d));
    chk({tag, ".valid"}, 8'(dir_valid), 8'(v));
    chk({tag, ".change"}, 8'(dir_change), 8'(c));
    chk({tag, ".err"}, 8'(err), 8'(e));
  endtask

  initial begin
    // Reset state
    gap(2);
    chk_out("rst", 2'b00, 1'b0, 1'b0, 1'b0);
    chk("rst.state", 8'(dut.state_reg), 8'(IDLE));
`ifdef RUNWAY_DECODER_ERRCNT_EN
    chk("rst.errcnt", err_count, 8'h00);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Calm lock: D,B,D,B -> locks after the 4th sample
    samp(D); chk_out("calm1", 2'b00, 1'b0, 1'b0, 1'b0);
    samp(B); chk_out("calm2", 2'b00, 1'b0, 1'b0, 1'b0);
    samp(D); chk_out("calm3", 2'b00, 1'b0, 1'b0, 1'b0);
    samp(B); chk_out("calm4", 2'b00, 1'b1, 1'b1, 1'b0);
    gap(1);  chk_out("calm_hold", 2'b00, 1'b1, 1'b0, 1'b0);
    // Saturation: further calm transitions stay locked with no new pulse
    samp(D); chk_out("calm_sat1", 2'b00, 1'b1, 1'b0, 1'b0);
    samp(B); chk_out("calm_sat2", 2'b00, 1'b1, 1'b0, 1'b0);
    samp(D); chk_out("calm_sat3", 2'b00, 1'b1, 1'b0, 1'b0);
    // D->D is illegal
    samp(D); chk_out("dd_err", 2'b00, 1'b0, 1'b0, 1'b1);
    chk("dd.state", 8'(dut.state_reg), 8'(IDLE));

    // Wind01 lock then switch to wind10
    do_reset();
    samp(A); samp(B); samp(C);
    chk_out("w01_pre", 2'b00, 1'b0, 1'b0, 1'b0);
    samp(A); chk_out("w01_lock", 2'b01, 1'b1, 1'b1, 1'b0);
    samp(C); chk_out("sw_c", 2'b01, 1'b0, 1'b0, 1'b0);
    samp(B); chk_out("sw_b", 2'b01, 1'b0, 1'b0, 1'b0);
    samp(A); chk_out("w10_lock", 2'b10, 1'b1, 1'b1, 1'b0);
    samp(C); chk_out("w10_sat", 2'b10, 1'b1, 1'b0, 1'b0);

    // Illegal pattern while locked: err pulse, IDLE, dir held
    samp(X); chk_out("ill_lock", 2'b10, 1'b0, 1'b0, 1'b1);
    chk("ill_lock.state", 8'(dut.state_reg), 8'(IDLE));
    gap(1);  chk_out("ill_after", 2'b10, 1'b0, 1'b0, 1'b0);

    // Repeat A,A: err then back to IDLE; next A,B,C,A locks wind01
    samp(A); chk_out("rep_a1", 2'b10, 1'b0, 1'b0, 1'b0);
    samp(A); chk_out("rep_a2", 2'b10, 1'b0, 1'b0, 1'b1);
    chk("rep.state", 8'(dut.state_reg), 8'(IDLE));
    samp(A); samp(B); samp(C);
    chk_out("rep_pre", 2'b10, 1'b0, 1'b0, 1'b0);
    samp(A); chk_out("rep_lock", 2'b01, 1'b1, 1'b1, 1'b0);

    // Calm sequence with sample_en gaps of 3, 0, 5 cycles
    do_reset();
    samp(D); chk_out("gap1", 2'b00, 1'b0, 1'b0, 1'b0);
    gap(3);
    samp(B); chk_out("gap2", 2'b00, 1'b0, 1'b0, 1'b0);
    samp(D); chk_out("gap3", 2'b00, 1'b0, 1'b0, 1'b0);
    gap(5);
    chk("gap.state", 8'(dut.state_reg), 8'(TRACK));
    samp(B); chk_out("gap4", 2'b00, 1'b1, 1'b1, 1'b0);

    // Async reset mid-LOCKED (right after lock, dir_change still high)
    #2 reset = 1'b1;
    #1 chk_out("areset_lock", 2'b00, 1'b0, 1'b0, 1'b0);
    chk("areset_lock.state", 8'(dut.state_reg), 8'(IDLE));
    @(negedge clk); reset = 1'b0;

    // Async reset mid-TRACK after wind10 locked then one calm transition
    samp(A); samp(C); samp(B); samp(A);
    chk_out("w10_lock2", 2'b10, 1'b1, 1'b1, 1'b0);
    samp(D); chk_out("trk", 2'b10, 1'b0, 1'b0, 1'b0);
    chk("trk.state", 8'(dut.state_reg), 8'(TRACK));
    #2 reset = 1'b1;
    #1 chk_out("areset_trk", 2'b00, 1'b0, 1'b0, 1'b0);
    chk("areset_trk.state", 8'(dut.state_reg), 8'(IDLE));
    @(negedge clk); reset = 1'b0;

`ifdef RUNWAY_DECODER_ERRCNT_EN
    // 300 illegal samples saturate the error counter
    for (int i = 0; i < 300; i++) begin
      pat = X; sample_en = 1'b1;
      @(negedge clk);
    end
    sample_en = 1'b0;
    chk("errcnt_sat", err_count, 8'hFF);
    chk("errcnt_err", 8'(err), 8'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/runway_decoder.md
Name: runway_decoder

Overview:
- Observer for the runway lights pattern bus: samples the 3-bit light pattern and infers which wind/switch code is driving the pattern generator.
- Classifies each pattern-to-pattern transition and requires CONFIRM consecutive agreeing transitions before reporting a direction.
- Flags illegal patterns and illegal transitions.
- Sits on the monitor/feedback side of the runway lights, for self-check and display.

Parameters:
- CONFIRM, 3: number of consecutive same-class transitions required to lock a direction. Legal range is 1..15.
- CNT_W, 4: width of the agreement counter. Must satisfy 2**CNT_W > CONFIRM.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_en  in  1  qualifies pat for one cycle; the pattern is evaluated only when this is 1.
- pat  in  3  observed light pattern.
- dir  out  2  decoded code: 2'b00 calm, 2'b01 wind01, 2'b10 wind10. The value 2'b11 is never driven.
- dir_valid  out  1  dir is locked.
- dir_change  out  1  one-cycle pulse when dir_valid rises, or when the locked dir value changes.
- err  out  1  one-cycle pulse on an illegal pattern or illegal transition.

Behaviour:
- Reset is asynchronous and active-high. Reset state:
  - state=IDLE, prev=3'b000, cand=2'b00, cnt=0
  - dir=2'b00, dir_valid=0, dir_change=0, err=0
- Reset asserted mid-lock drops dir_valid immediately, with no err pulse.
- All outputs are registered. The response appears one clock after the edge at which sample_en=1 is sampled.
- Cycles with sample_en=0 change no state. dir_change and err return to 0 on those cycles.
- Legal patterns: A=001, B=010, C=100, D=101. Any other pattern is illegal.
- Transition classes (prev->cur):
  - calm: A->D, B->D, C->D, D->B.
  - wind01: A->B, B->C, C->A, D->A.
  - wind10: A->C, C->B, B->A, D->C.
  - Every other pair is illegal, including cur==prev and C->D->... pairs not listed, e.g. D->D.
- State machine:
  - IDLE, with a legal pat: prev<=pat, cnt<=0, go to TRACK.
  - IDLE, with an illegal pat: pulse err, stay in IDLE.
  - TRACK or LOCKED, with an illegal pattern or illegal transition: pulse err, go to IDLE, dir_valid<=0. dir holds its last value.
  - TRACK or LOCKED, with a legal transition of class k:
    - prev<=pat.
    - If k==cand and cnt>0: cnt<=min(cnt+1, CONFIRM). Otherwise: cand<=k, cnt<=1.
  - TRACK: when the updated cnt==CONFIRM, set dir<=cand, dir_valid<=1, pulse dir_change, and go to LOCKED.
  - LOCKED, with a transition of a different class: dir_valid<=0, go to TRACK with cand=k, cnt=1.
  - When CONFIRM=1, that same transition re-locks immediately to the new dir and pulses dir_change. dir_valid stays 1 in this case.
- Lock latency from IDLE is CONFIRM+1 sampled patterns.
- The counter saturates at CONFIRM and never wraps.

Optional Feature:
- Macro: RUNWAY_DECODER_ERRCNT_EN.
- When defined:
  - Adds output port err_count [7:0].
  - err_count increments on every err pulse and saturates at 8'hFF.
  - It is cleared only by reset.
- When undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Package runway_pkg holds:
  - localparams PAT_A=3'b001, PAT_B=3'b010, PAT_C=3'b100, PAT_D=3'b101.
  - typedef enum logic [1:0] dir_t {DIR_CALM=2'b00, DIR_W01=2'b01, DIR_W10=2'b10}.
  - typedef enum dec_state_t {IDLE, TRACK, LOCKED}.
- Sub-module runway_xition_classify: combinational (prev, cur) -> {legal, dir_t cls}. It is instantiated once in runway_decoder.

Test Plan:
- Reset, then sample D,B,D,B with CONFIRM=3:
  - dir_valid=1 and dir=2'b00 one clock after the 4th sample.
  - dir_change pulses exactly once.
- Lock on A,B,C,A, then sample C,B,A,C:
  - dir_valid=0 after the C sample.
  - It re-locks with dir=2'b10 after the 3rd wind10 transition.
  - dir_change pulses on the re-lock.
- While locked, sample pat=3'b111: err pulses 1 cycle, dir_valid=0, state=IDLE, dir keeps its old value.
- Sample A then A (repeat): err pulses and the block returns to IDLE. The next legal A,B,C,A sequence locks dir=2'b01.
- Insert sample_en=0 gaps of 0..5 cycles between samples in the calm sequence: identical result to the gapless case, and no err.
- Assert reset asynchronously mid-TRACK and mid-LOCKED: outputs reach reset values without waiting for a clk edge.
- With RUNWAY_DECODER_ERRCNT_EN: 300 illegal samples give err_count=8'hFF.
